// File: rtl/mem_store_buffer.sv
// mem_store_buffer: 256-byte data memory fronted by an in-order store buffer.
// Stores are posted into a circular buffer and retired one per cycle into the
// backing array; loads are combinational and forward from the youngest
// matching buffered store, falling back to the array.
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_w_en,
  input  logic [7:0]               mem_w_addr,
  input  logic [7:0]               mem_w_data,
  input  logic                     mem_r_en,
  input  logic [7:0]               mem_r_addr,
  output logic [7:0]               mem_r_data,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_full,
  output logic                     buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    buf_addr [DEPTH];
  logic [7:0]    buf_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [7:0]    mem [256];
  logic          drain;

  // Retire the oldest entry when idle, or when full so an incoming store has room.
  always_comb begin
    drain = (count != '0) && (!mem_w_en || (count == FULL_CNT));
  end

  // Buffer bookkeeping and array retirement; reset discards the buffer and clears the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < 256; i++) begin
        mem[8'(i)] <= '0;
      end
    end else begin
      if (mem_w_en) begin
        buf_addr[tail] <= mem_w_addr;
        buf_data[tail] <= mem_w_data;
        tail           <= tail + PW'(1);
      end
      // When full, tail == head: the head entry is read here before the
      // enqueue above overwrites it, so the store-while-full case is safe.
      if (drain) begin
        mem[buf_addr[head]] <= buf_data[head];
        head                <= head + PW'(1);
      end
      case ({mem_w_en, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Load path: array value, overridden by each matching valid entry from oldest
  // to youngest so the youngest match wins, including across pointer wrap.
  always_comb begin
    mem_r_data = '0;
    if (mem_r_en) begin
      mem_r_data = mem[mem_r_addr];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (buf_addr[head + PW'(i)] == mem_r_addr)) begin
          mem_r_data = buf_data[head + PW'(i)];
        end
      end
    end
  end

  // Occupancy status.
  always_comb begin
    buf_count = count;
    buf_full  = (count == FULL_CNT);
    buf_empty = (count == '0);
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed expected values.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       mem_w_en;
  logic [7:0] mem_w_addr;
  logic [7:0] mem_w_data;
  logic       mem_r_en;
  logic [7:0] mem_r_addr;
  logic [7:0] mem_r_data;
  logic [2:0] buf_count;
  logic       buf_full;
  logic       buf_empty;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .buf_count  (buf_count),
    .buf_full   (buf_full),
    .buf_empty  (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO of pending stores and a plain byte array.
  typedef struct packed { logic [7:0] a; logic [7:0] d; } ent_t;
  ent_t       q[$];
  logic [7:0] mem_m [256];
  bit         model_ready = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      model_ready = 1;
    end else if (model_ready) begin
      if (q.size() != 0 && (!mem_w_en || q.size() == DEPTH)) begin
        ent_t e;
        e = q.pop_front();
        mem_m[e.a] = e.d;
      end
      if (mem_w_en) q.push_back('{a: mem_w_addr, d: mem_w_data});
    end
  end

  function automatic logic [7:0] model_read(input logic en, input logic [7:0] addr);
    if (!en) return 8'h00;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == addr) return q[i].d;
    return mem_m[addr];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ready) begin
      check("model_count", 8'(buf_count), 8'(q.size()));
      check("model_full",  8'(buf_full),  8'(q.size() == DEPTH));
      check("model_empty", 8'(buf_empty), 8'(q.size() == 0));
      check("model_rdata", mem_r_data, model_read(mem_r_en, mem_r_addr));
    end
  end

  task automatic drive(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic r, input logic [7:0] ra);
    @(posedge clk);
    #1;
    mem_w_en = w; mem_w_addr = wa; mem_w_data = wd;
    mem_r_en = r; mem_r_addr = ra;
    @(negedge clk);
  endtask

  logic [7:0] exp_cnt [6];

  initial begin
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
    rst = 1'b1;
    mem_w_en = 0; mem_w_addr = '0; mem_w_data = '0;
    mem_r_en = 0; mem_r_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset read
    mem_r_en = 1; mem_r_addr = 8'h05;
    @(negedge clk);
    check("reset_rdata", mem_r_data, 8'h00);
    check("reset_empty", 8'(buf_empty), 8'd1);
    check("reset_full",  8'(buf_full),  8'd0);
    check("reset_count", 8'(buf_count), 8'd0);

    // Store then load
    drive(1, 8'h10, 8'hAB, 0, 8'h10);
    check("rd_disabled", mem_r_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h10);
    check("fwd_AB", mem_r_data, 8'hAB);
    check("count_1", 8'(buf_count), 8'd1);
    drive(0, 8'h00, 8'h00, 1, 8'h10);
    check("count_0", 8'(buf_count), 8'd0);
    check("array_AB", mem_r_data, 8'hAB);

    // Youngest-wins forwarding
    drive(1, 8'h20, 8'h11, 0, 8'h00);
    drive(1, 8'h20, 8'h22, 0, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h20);
    check("youngest_fwd", mem_r_data, 8'h22);
    check("dup_count", 8'(buf_count), 8'd2);
    drive(0, 8'h00, 8'h00, 1, 8'h20);
    drive(0, 8'h00, 8'h00, 1, 8'h20);
    check("dup_empty", 8'(buf_empty), 8'd1);
    check("youngest_array", mem_r_data, 8'h22);

    // Full and wrap
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'(8'h30 + k), 8'(8'h30 + k) ^ 8'hFF, 0, 8'h00);
      if (k > 0) check("wrap_count", 8'(buf_count), exp_cnt[k-1]);
      if (k == 4) check("wrap_full", 8'(buf_full), 8'd1);
    end
    drive(0, 8'h00, 8'h00, 1, 8'h35);
    check("wrap_count_last", 8'(buf_count), exp_cnt[5]);
    check("wrap_fwd_35", mem_r_data, 8'hCA);
    for (int k = 0; k < 3; k++) drive(0, 8'h00, 8'h00, 0, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h30);
    check("wrap_drained_empty", 8'(buf_empty), 8'd1);
    check("wrap_drained_full", 8'(buf_full), 8'd0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 8'h00, 8'h00, 1, 8'(8'h30 + k));
      check("wrap_load", mem_r_data, 8'(8'hCF - k));
    end

    // Reset mid-operation
    drive(1, 8'h40, 8'h01, 0, 8'h00);
    drive(1, 8'h41, 8'h02, 0, 8'h00);
    drive(1, 8'h42, 8'h03, 0, 8'h00);
    @(posedge clk);
    #1;
    mem_w_en = 0; rst = 1'b1;
    @(negedge clk);
    check("pre_rst_count", 8'(buf_count), 8'd3);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_r_en = 1; mem_r_addr = 8'h40;
    @(negedge clk);
    check("rst_count", 8'(buf_count), 8'd0);
    check("rst_load_40", mem_r_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h41);
    check("rst_load_41", mem_r_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h42);
    check("rst_load_42", mem_r_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h30);
    check("rst_array_cleared", mem_r_data, 8'h00);

    // Simultaneous store and load
    drive(1, 8'h50, 8'h55, 0, 8'h00);
    drive(0, 8'h00, 8'h00, 0, 8'h00);
    drive(1, 8'h50, 8'h66, 1, 8'h50);
    check("simul_old", mem_r_data, 8'h55);
    drive(0, 8'h00, 8'h00, 1, 8'h50);
    check("simul_new", mem_r_data, 8'h66);

    drive(0, 8'h00, 8'h00, 0, 8'h00);
    drive(0, 8'h00, 8'h00, 0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
